// File: rtl/interval_timer_pkg.sv
// Shared definitions for the interval timer: controller state encoding and default width.
// Optional prescaler is enabled by defining INTERVAL_TIMER_PRESCALE_EN.
package interval_timer_pkg;

   localparam int DEFAULT_SIZE = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } timer_state_t;

endpackage

// File: rtl/interval_step_counter.sv
// Step counter for the interval timer: clear, enable and a terminal-count compare
// against period-1, all modulo 2^size so a zero period spans the full range.
module interval_step_counter
   import interval_timer_pkg::*;
#(
   parameter int size = DEFAULT_SIZE
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            enable,
   input  logic [size-1:0] period,
   output logic [size-1:0] count,
   output logic            terminal
);

   logic [size-1:0] last;

   // A zero period wraps to all-ones here, giving 2^size steps per interval.
   assign last     = period - size'(1);
   assign terminal = (count == last);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= terminal ? '0 : count + size'(1);
      end
   end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: configuration handshake, IDLE/RUN/DONE sequencing, tick and phase.
// Define INTERVAL_TIMER_PRESCALE_EN to slow count steps to one per 'prescale' clock cycles.
module interval_timer_ctrl
   import interval_timer_pkg::*;
#(
   parameter int size = DEFAULT_SIZE
`ifdef INTERVAL_TIMER_PRESCALE_EN
   ,
   parameter int prescale = 4
`endif
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   input  logic [size-1:0] cfg_period,
   input  logic            cfg_periodic,
   input  logic            start,
   input  logic            stop,
   output logic            busy,
   output logic            tick,
   output logic [size-1:0] count,
   output logic            phase
);

   timer_state_t    state;
   logic [size-1:0] period_reg;
   logic            periodic_reg;
   logic [size-1:0] half;
   logic            cfg_accept;
   logic            step;
   logic            terminal;
   logic            counter_clear;
   logic            expire;

   assign cfg_accept = cfg_valid && (state == IDLE);

`ifdef INTERVAL_TIMER_PRESCALE_EN
   localparam int PW = (prescale > 1) ? $clog2(prescale) : 1;
   logic [PW-1:0] pre;

   // Prescaler only runs in RUN, so it is zero again whenever a run starts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre <= '0;
      end else if ((state != RUN) || stop) begin
         pre <= '0;
      end else if (pre == PW'(prescale - 1)) begin
         pre <= '0;
      end else begin
         pre <= pre + PW'(1);
      end
   end

   assign step = (state == RUN) && (pre == PW'(prescale - 1));
`else
   assign step = (state == RUN);
`endif

   // Stop takes priority over an expiry landing in the same cycle.
   assign counter_clear = (state != RUN) || stop;
   assign expire        = (state == RUN) && step && terminal && !stop;

   interval_step_counter #(
      .size(size)
   ) u_counter (
      .clk     (clk),
      .reset   (reset),
      .clear   (counter_clear),
      .enable  (step),
      .period  (period_reg),
      .count   (count),
      .terminal(terminal)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         tick         <= 1'b0;
         period_reg   <= '0;
         periodic_reg <= 1'b0;
      end else begin
         tick <= expire;
         if (cfg_accept) begin
            period_reg   <= cfg_period;
            periodic_reg <= cfg_periodic;
         end
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (stop) begin
                  state <= IDLE;
               end else if (expire && !periodic_reg) begin
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Half of a zero period means half of 2^size.
   always_comb begin
      half = period_reg >> 1;
      if (period_reg == '0) begin
         half = size'(1) << (size - 1);
      end
   end

   assign busy      = (state == RUN);
   assign cfg_ready = (state == IDLE);
   assign phase     = busy && (count >= half);

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench for interval_timer_ctrl (default build, no prescaler): directed
// scenarios with literal expectations plus randomized traffic against an elapsed-step model.
module tb_interval_timer_ctrl;

   localparam int SIZE = 12;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            cfg_valid = 1'b0;
   logic            cfg_ready;
   logic [SIZE-1:0] cfg_period = '0;
   logic            cfg_periodic = 1'b0;
   logic            start = 1'b0;
   logic            stop = 1'b0;
   logic            busy;
   logic            tick;
   logic [SIZE-1:0] count;
   logic            phase;

   int checks = 0;
   int failures = 0;

   interval_timer_ctrl #(
      .size(SIZE)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_period  (cfg_period),
      .cfg_periodic(cfg_periodic),
      .start       (start),
      .stop        (stop),
      .busy        (busy),
      .tick        (tick),
      .count       (count),
      .phase       (phase)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s at %0t: actual=%0d expected=%0d", name, $time, actual, expected);
      end
   endtask

   // Reference model: a run is described by its step count since start and its period.
   bit m_running = 1'b0;
   bit m_done = 1'b0;
   int m_elapsed = 0;
   int m_p = 1 << SIZE;
   bit m_periodic = 1'b0;
   int held_p = 1 << SIZE;
   bit held_periodic = 1'b0;

   always @(posedge clk) begin
      bit idle_now;
      int e_count, e_busy, e_tick, e_phase, e_ready;
      if (!reset) begin
         m_running = 1'b0;
         m_done = 1'b0;
         m_elapsed = 0;
         held_p = 1 << SIZE;
         held_periodic = 1'b0;
      end else begin
         idle_now = !m_running && !m_done;
         if (idle_now && cfg_valid) begin
            held_p = (cfg_period == 0) ? (1 << SIZE) : int'(cfg_period);
            held_periodic = cfg_periodic;
         end
         if (m_done) begin
            m_done = 1'b0;
         end else if (m_running) begin
            if (stop) begin
               m_running = 1'b0;
               m_elapsed = 0;
            end else begin
               m_elapsed++;
               if (!m_periodic && m_elapsed == m_p) begin
                  m_running = 1'b0;
                  m_done = 1'b1;
                  m_elapsed = 0;
               end
            end
         end else if (start && !stop) begin
            m_running = 1'b1;
            m_elapsed = 0;
            m_p = held_p;
            m_periodic = held_periodic;
         end
      end
      #1;
      if (m_running) begin
         e_count = m_elapsed % m_p;
         e_busy = 1;
         e_tick = (m_elapsed > 0 && e_count == 0) ? 1 : 0;
         e_phase = (e_count >= m_p / 2) ? 1 : 0;
         e_ready = 0;
      end else if (m_done) begin
         e_count = 0; e_busy = 0; e_tick = 1; e_phase = 0; e_ready = 0;
      end else begin
         e_count = 0; e_busy = 0; e_tick = 0; e_phase = 0; e_ready = 1;
      end
      check_output("model_count", int'(count), e_count);
      check_output("model_busy", int'(busy), e_busy);
      check_output("model_tick", int'(tick), e_tick);
      check_output("model_phase", int'(phase), e_phase);
      check_output("model_cfg_ready", int'(cfg_ready), e_ready);
   end

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_stimulus(input bit v, input int per, input bit pd, input bit st, input bit sp);
      cfg_valid = v;
      cfg_period = SIZE'(per);
      cfg_periodic = pd;
      start = st;
      stop = sp;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL timeout at %0t", $time);
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      int ticks;
      int maxc;
      int steps;
      bit found;

      // Reset held, then released with no activity.
      apply_stimulus(0, 0, 0, 0, 0);
      repeat (3) next_cycle();
      check_output("rst_count", int'(count), 0);
      check_output("rst_busy", int'(busy), 0);
      reset = 1'b1;
      next_cycle();
      check_output("idle_tick", int'(tick), 0);
      check_output("idle_ready", int'(cfg_ready), 1);
      check_output("idle_phase", int'(phase), 0);

      // Period 5 one-shot.
      apply_stimulus(1, 5, 0, 0, 0);
      next_cycle();
      apply_stimulus(0, 0, 0, 1, 0);
      next_cycle();
      apply_stimulus(0, 0, 0, 0, 0);
      check_output("os_busy0", int'(busy), 1);
      check_output("os_count0", int'(count), 0);
      for (int i = 1; i <= 4; i++) begin
         next_cycle();
         check_output("os_count", int'(count), i);
         check_output("os_busy", int'(busy), 1);
         check_output("os_tick_early", int'(tick), 0);
      end
      next_cycle();
      check_output("os_done_tick", int'(tick), 1);
      check_output("os_done_count", int'(count), 0);
      check_output("os_done_busy", int'(busy), 0);
      check_output("os_done_ready", int'(cfg_ready), 0);
      next_cycle();
      check_output("os_after_ready", int'(cfg_ready), 1);
      check_output("os_after_tick", int'(tick), 0);

      // Period 4 periodic, config and start together.
      apply_stimulus(1, 4, 1, 1, 0);
      next_cycle();
      apply_stimulus(0, 0, 0, 0, 0);
      ticks = 0;
      for (int i = 1; i <= 20; i++) begin
         next_cycle();
         ticks += int'(tick);
         check_output("p4_count", int'(count), i % 4);
         check_output("p4_phase", int'(phase), (i % 4 >= 2) ? 1 : 0);
      end
      check_output("p4_ticks", ticks, 5);
      apply_stimulus(0, 0, 0, 0, 1);
      next_cycle();
      check_output("p4_stop_busy", int'(busy), 0);

      // Period 0 means 4096 steps.
      apply_stimulus(1, 0, 1, 1, 0);
      next_cycle();
      apply_stimulus(0, 0, 0, 0, 0);
      maxc = 0;
      steps = 0;
      found = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         next_cycle();
         steps++;
         if (int'(count) > maxc) maxc = int'(count);
         if (tick) begin
            found = 1'b1;
            break;
         end
      end
      check_output("p0_tick_seen", int'(found), 1);
      check_output("p0_steps", steps, 4096);
      check_output("p0_max", maxc, 4095);
      check_output("p0_wrap", int'(count), 0);
      check_output("p0_busy", int'(busy), 1);
      apply_stimulus(0, 0, 0, 0, 1);
      next_cycle();

      // Period 3, stop exactly on the last count before expiry.
      apply_stimulus(1, 3, 1, 1, 0);
      next_cycle();
      apply_stimulus(0, 0, 0, 0, 0);
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (count == SIZE'(2)) begin
            found = 1'b1;
            break;
         end
         next_cycle();
      end
      check_output("p3_wait_count2", int'(found), 1);
      apply_stimulus(0, 0, 0, 0, 1);
      next_cycle();
      check_output("p3_stop_busy", int'(busy), 0);
      check_output("p3_stop_count", int'(count), 0);
      check_output("p3_stop_tick", int'(tick), 0);
      check_output("p3_stop_ready", int'(cfg_ready), 1);
      apply_stimulus(0, 0, 0, 1, 1);
      next_cycle();
      apply_stimulus(0, 0, 0, 0, 0);
      check_output("ss_busy", int'(busy), 0);
      check_output("ss_ready", int'(cfg_ready), 1);

      // Reset in the middle of a run.
      apply_stimulus(1, 5, 1, 1, 0);
      next_cycle();
      apply_stimulus(0, 0, 0, 0, 0);
      next_cycle();
      next_cycle();
      reset = 1'b0;
      #1;
      check_output("mr_busy", int'(busy), 0);
      check_output("mr_count", int'(count), 0);
      next_cycle();
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         check_output("mr_no_tick", int'(tick), 0);
      end

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         apply_stimulus(($urandom % 4) == 0,
                        (($urandom % 8) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 9)),
                        $urandom % 2,
                        ($urandom % 4) == 0,
                        ($urandom % 12) == 0);
         reset = (($urandom % 500) == 0) ? 1'b0 : 1'b1;
         next_cycle();
      end
      reset = 1'b1;
      apply_stimulus(0, 0, 0, 0, 0);
      repeat (2) next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/interval_timer_ctrl.md
INTERVAL_TIMER_CTRL -- requirements
Module: interval_timer_ctrl

Interface
REQ-001 Parameter: size, 12, width of period and count values (>= 2).
REQ-002 Parameter: prescale, 4, clock cycles per count step (>= 1); present only with INTERVAL_TIMER_PRESCALE_EN.
REQ-003 clk  input  1  single clock, rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cfg_valid  input  1  configuration offered.
REQ-006 cfg_ready  output  1  configuration can be accepted.
REQ-007 cfg_period  input  size  period in count steps; 0 means 2^size.
REQ-008 cfg_periodic  input  1  1 = auto-reload, 0 = one-shot.
REQ-009 start  input  1  begin counting.
REQ-010 stop  input  1  abort counting.
REQ-011 busy  output  1  high in RUN.
REQ-012 tick  output  1  one-cycle pulse at period expiry.
REQ-013 count  output  size  current count value.
REQ-014 phase  output  1  high when count >= period/2 (integer divide); low outside RUN.

Function
REQ-015 FSM states IDLE, RUN, DONE; IDLE after reset.
REQ-016 cfg_ready = 1 only in IDLE; config latched on the cycle cfg_valid && cfg_ready; the held period register is otherwise unchanged.
REQ-017 IDLE + start -> RUN next cycle, count = 0.
REQ-018 Start with no config ever accepted uses period 0 (2^size), one-shot.
REQ-019 RUN: count increments by 1 per step; a step is every cycle without the macro.
REQ-020 Step when count == period-1 (mod 2^size): tick = 1 in the following cycle, coincident with count = 0.
REQ-021 Periodic: remain in RUN after expiry, wrap to 0.
REQ-022 One-shot: go to DONE on expiry; DONE lasts exactly one cycle, then IDLE.
REQ-023 Period 1: tick every step, count stays 0.
REQ-024 RUN + stop -> IDLE next cycle, count = 0, no tick, even if the same cycle would have expired.
REQ-025 start and stop together: stop wins; in IDLE, nothing happens.
REQ-026 start in RUN or DONE: ignored.
REQ-027 cfg_valid in the same cycle as start in IDLE: config latched first; the run uses the new period.
REQ-028 Internal count and period arithmetic is size bits, modulo 2^size; no overflow flag.

Reset
REQ-029 reset low: state IDLE, count 0, tick 0, busy 0, phase 0, cfg_ready 1 (after reset released), period register 0, periodic 0, prescaler 0.
REQ-030 Reset asserted mid-RUN aborts immediately; no tick is generated on release.

Configuration
REQ-031 Macro INTERVAL_TIMER_PRESCALE_EN defined: a prescale-cycle prescaler gates steps; the first step occurs prescale cycles after entering RUN; tick stays one clk cycle wide; the prescaler clears on stop, start and reset.
REQ-032 Macro undefined: no prescaler logic and no prescale parameter; one step per cycle.

Structure
REQ-033 Shared package interval_timer_pkg holds the state enum (IDLE/RUN/DONE) and the default size constant.
REQ-034 Single sub-module interval_step_counter: size-bit counter with clear, enable and terminal-count compare; the FSM lives in the top.

Verification
REQ-035 Reset 0 then 1, no activity -> count 0, busy 0, tick 0, cfg_ready 1.
REQ-036 Config period 5 one-shot, start -> busy for 5 cycles, count 0..4, tick once with count back to 0, DONE one cycle, cfg_ready 1 after.
REQ-037 Config period 4 periodic, run 20 cycles -> tick every 4th cycle (5 ticks), phase high at count 2 and 3.
REQ-038 Period 0, size 12, periodic -> count reaches 4095, tick after 4096 steps, wrap to 0.
REQ-039 Period 3 periodic, assert stop exactly on the count==2 cycle -> no tick, IDLE, count 0; then start and stop together -> stays IDLE.
REQ-040 With INTERVAL_TIMER_PRESCALE_EN, prescale 4, period 2 one-shot -> count 1 at cycle 4, tick at cycle 8, tick width one cycle; reset pulled low at cycle 6 -> IDLE, no tick.
